// File: rtl/filtro_pkg.sv
// Shared definitions for the multiband biquad filter bank.
//   estado_t     : sequencing states of the shared multiply/accumulate datapath
//   IDX_B0..A2   : coefficient slot numbers within a band (a1/a2 stored pre-negated)
//   ONE          : Q-format 1.0 for the default 14 fractional bits
//   reduce_word  : narrows a wide signed value to w bits
// Optional build macro: FILTRO_SATURACION_EN. When it is defined, reduce_word saturates.
// When it is undefined, reduce_word keeps the low w bits (two's-complement wrap).
package filtro_pkg;

    typedef enum logic [2:0] {
        IDLE, S_A1, S_A2, S_B0, S_B1, S_B2, DONE
    } estado_t;

    localparam logic [2:0] IDX_B0 = 3'd0;
    localparam logic [2:0] IDX_B1 = 3'd1;
    localparam logic [2:0] IDX_B2 = 3'd2;
    localparam logic [2:0] IDX_A1 = 3'd3;
    localparam logic [2:0] IDX_A2 = 3'd4;

    localparam int PRESICION_Q = 14;
    localparam int ONE         = 1 << PRESICION_Q;

    // The result is sign-extended back to 64 bits; the caller slices off the low w bits.
    function automatic logic signed [63:0] reduce_word(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
`ifdef FILTRO_SATURACION_EN
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        else             return v;
`else
        hi = v <<< (64 - w);
        lo = hi >>> (64 - w);
        return lo;
`endif
    endfunction

endpackage

// File: rtl/mult_punto_fijo.sv
// Combinational signed fixed-point multiplier.
// It forms the full 2*Width product, then shifts it arithmetically right by Presicion.
// The shift truncates toward -inf.
//   a, b : Width-bit signed operands
//   p    : 2*Width-bit signed scaled product
module mult_punto_fijo #(
    parameter int Width     = 22,
    parameter int Presicion = 14
) (
    input  logic signed [Width-1:0]   a,
    input  logic signed [Width-1:0]   b,
    output logic signed [2*Width-1:0] p
);

    logic signed [2*Width-1:0] full;

    assign full = (2*Width)'(a) * (2*Width)'(b);
    assign p    = full >>> Presicion;

endmodule

// File: rtl/filtro_biquad_multibanda.sv
// Time-multiplexed biquad IIR bank (direct form II).
// NBANDS sections share one multiplier and one adder.
// A sample takes 7 cycles: IDLE, A1, A2, B0, B1, B2, DONE.
// Ports:
//   clk150kHz, reset (async, active-low)
//   in_valid/in_ready/band_sel/uk : sample input, accepted only in IDLE
//   out_valid/yk                  : one-cycle pulse; yk is held between pulses
//   coef_we/coef_band/coef_idx/coef_data : coefficient write port, live in any cycle
//   flush                         : clears every band's w1/w2; coefficients are kept
// Optional build macro: FILTRO_SATURACION_EN. When defined, fk and yk saturate.
// When undefined, fk and yk wrap.
module filtro_biquad_multibanda
    import filtro_pkg::*;
#(
    parameter  int Width     = 22,
    parameter  int Presicion = 14,
    parameter  int NBANDS    = 3,
    localparam int BW        = (NBANDS > 1) ? $clog2(NBANDS) : 1
) (
    input  logic                    clk150kHz,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BW-1:0]           band_sel,
    input  logic signed [Width-1:0] uk,
    output logic                    out_valid,
    output logic signed [Width-1:0] yk,
    input  logic                    coef_we,
    input  logic [BW-1:0]           coef_band,
    input  logic [2:0]              coef_idx,
    input  logic signed [Width-1:0] coef_data,
    input  logic                    flush
);

    localparam int ACC_W = Width + 2;

    estado_t state, state_nx;

    logic signed [Width-1:0] coef_mem [NBANDS][5];
    logic signed [Width-1:0] w1_mem   [NBANDS];
    logic signed [Width-1:0] w2_mem   [NBANDS];

    logic signed [Width-1:0]   uk_q, fk_q;
    logic [BW-1:0]             band_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic                      flush_pend;

    logic                      accept, band_ok, clr_all, upd_ok;
    logic [BW-1:0]             band_idx;
    logic signed [Width-1:0]   w1_cur, w2_cur, mul_c, mul_d;
    logic signed [2*Width-1:0] prod;
    logic signed [ACC_W-1:0]   add_a, sum;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;

    // An out-of-range band reads zero coefficients and zero state, and it never writes back.
    assign band_ok  = int'(band_q) < NBANDS;
    assign band_idx = band_ok ? band_q : '0;
    assign w1_cur   = band_ok ? w1_mem[band_idx] : '0;
    assign w2_cur   = band_ok ? w2_mem[band_idx] : '0;

    // A flush raised while busy is held until DONE. The running sample still uses its old state.
    assign clr_all = (flush && state == IDLE) || (state == DONE && (flush || flush_pend));
    assign upd_ok  = band_ok && !flush && !flush_pend;

    // The coefficients are read live in each phase, so a write lands from the next phase on.
    always_comb begin
        mul_c = '0;
        mul_d = '0;
        add_a = '0;
        case (state)
            S_A1: begin
                mul_c = band_ok ? coef_mem[band_idx][IDX_A1] : '0;
                mul_d = w1_cur;
                add_a = ACC_W'(uk_q);
            end
            S_A2: begin
                mul_c = band_ok ? coef_mem[band_idx][IDX_A2] : '0;
                mul_d = w2_cur;
                add_a = acc_q;
            end
            S_B0: begin
                mul_c = band_ok ? coef_mem[band_idx][IDX_B0] : '0;
                mul_d = fk_q;
            end
            S_B1: begin
                mul_c = band_ok ? coef_mem[band_idx][IDX_B1] : '0;
                mul_d = w1_cur;
                add_a = acc_q;
            end
            S_B2: begin
                mul_c = band_ok ? coef_mem[band_idx][IDX_B2] : '0;
                mul_d = w2_cur;
                add_a = acc_q;
            end
            default: ;
        endcase
    end

    mult_punto_fijo #(.Width(Width), .Presicion(Presicion)) u_mult (
        .a (mul_c),
        .b (mul_d),
        .p (prod)
    );

    assign sum = add_a + ACC_W'(prod);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = S_A1;
            S_A1:    state_nx = S_A2;
            S_A2:    state_nx = S_B0;
            S_B0:    state_nx = S_B1;
            S_B1:    state_nx = S_B2;
            S_B2:    state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk150kHz or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // ---- datapath registers: input latch, accumulator, fk, output ----
    always_ff @(posedge clk150kHz or negedge reset) begin
        if (!reset) begin
            uk_q       <= '0;
            band_q     <= '0;
            acc_q      <= '0;
            fk_q       <= '0;
            yk         <= '0;
            out_valid  <= 1'b0;
            flush_pend <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (state == DONE)
                flush_pend <= 1'b0;
            else if (flush && state != IDLE)
                flush_pend <= 1'b1;
            case (state)
                IDLE: if (accept) begin
                    uk_q   <= uk;
                    band_q <= band_sel;
                end
                S_A2: fk_q <= Width'(reduce_word(64'(sum), Width));
                S_A1, S_B0, S_B1, S_B2: acc_q <= sum;
                DONE: begin
                    yk        <= band_ok ? Width'(reduce_word(64'(acc_q), Width)) : '0;
                    out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ---- per-band delay state ----
    always_ff @(posedge clk150kHz or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < NBANDS; b++) begin
                w1_mem[b] <= '0;
                w2_mem[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NBANDS; b++) begin
                if (clr_all) begin
                    w1_mem[b] <= '0;
                    w2_mem[b] <= '0;
                end else if (state == S_B2 && upd_ok && band_q == BW'(b)) begin
                    w2_mem[b] <= w1_mem[b];
                    w1_mem[b] <= fk_q;
                end
            end
        end
    end

    // ---- coefficient RAM; slot numbers 5..7 and bands beyond NBANDS match no register ----
    always_ff @(posedge clk150kHz or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < NBANDS; b++)
                for (int i = 0; i < 5; i++)
                    coef_mem[b][i] <= '0;
        end else if (coef_we) begin
            for (int b = 0; b < NBANDS; b++)
                for (int i = 0; i < 5; i++)
                    if (coef_band == BW'(b) && coef_idx == 3'(i))
                        coef_mem[b][i] <= coef_data;
        end
    end

endmodule

// File: tb/tb_filtro_biquad_multibanda.sv
module tb_filtro_biquad_multibanda;
    import filtro_pkg::*;

    logic               clk150kHz = 1'b0;
    logic               reset     = 1'b0;
    logic               in_valid  = 1'b0;
    logic               in_ready;
    logic [1:0]         band_sel  = '0;
    logic signed [21:0] uk        = '0;
    logic               out_valid;
    logic signed [21:0] yk;
    logic               coef_we   = 1'b0;
    logic [1:0]         coef_band = '0;
    logic [2:0]         coef_idx  = '0;
    logic signed [21:0] coef_data = '0;
    logic               flush     = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;
    logic signed [21:0] exp_q[$];

    filtro_biquad_multibanda #(.Width(22), .Presicion(14), .NBANDS(3)) dut (
        .clk150kHz (clk150kHz),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .band_sel  (band_sel),
        .uk        (uk),
        .out_valid (out_valid),
        .yk        (yk),
        .coef_we   (coef_we),
        .coef_band (coef_band),
        .coef_idx  (coef_idx),
        .coef_data (coef_data),
        .flush     (flush)
    );

    always #5 clk150kHz = ~clk150kHz;

    task automatic tick();
        @(posedge clk150kHz);
        #1;
    endtask

    task automatic write_coef(input int band, input int idx, input int val);
        coef_we   = 1'b1;
        coef_band = 2'(band);
        coef_idx  = 3'(idx);
        coef_data = 22'(val);
        tick();
        coef_we = 1'b0;
    endtask

    task automatic set_band(input int band, input int b0, input int b1, input int b2,
                            input int a1, input int a2);
        write_coef(band, 0, b0);
        write_coef(band, 1, b1);
        write_coef(band, 2, b2);
        write_coef(band, 3, a1);
        write_coef(band, 4, a2);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    // flush_at: 0 = none, 100 = together with accept, k = sampled at k-th edge after accept.
    // lat is -1 if out_valid never came within the bound.
    task automatic drive_sample(input int band, input int u, input int flush_at,
                                output logic signed [21:0] y, output int lat);
        for (int k = 0; k < 20 && !in_ready; k++) tick();
        in_valid = 1'b1;
        band_sel = 2'(band);
        uk       = 22'(u);
        if (flush_at == 100) flush = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        lat = -1;
        y   = '0;
        for (int c = 1; c <= 20; c++) begin
            if (flush_at == c) flush = 1'b1;
            tick();
            flush = 1'b0;
            if (out_valid) begin
                lat = c;
                y   = yk;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic signed [21:0] y, e;
        int lat;
        reset = 1'b0;
        repeat (3) tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (yk !== 22'sd0) begin n_fail++; $display("FAIL reset_yk: got %0d want 0", yk); end
        reset = 1'b1;
        tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
        exp_q.push_back(22'sd0);
        drive_sample(0, 1234, 0, y, lat);
        e = exp_q.pop_front();
        n_cmp++; if (y !== e) begin n_fail++; $display("FAIL zero_coefs: yk %0d want %0d", y, e); end
        n_cmp++; if (lat != 6) begin n_fail++; $display("FAIL zero_coefs_latency: got %0d want 6", lat); end
    endtask

    task automatic test_passthrough();
        int us[3] = '{1000, -1000, 0};
        logic signed [21:0] y, e;
        int lat;
        set_band(0, ONE, 0, 0, 0, 0);
        do_flush();
        foreach (us[i]) exp_q.push_back(22'(us[i]));
        foreach (us[i]) begin
            drive_sample(0, us[i], 0, y, lat);
            e = exp_q.pop_front();
            n_cmp++; if (y !== e) begin n_fail++; $display("FAIL passthrough[%0d]: yk %0d want %0d", i, y, e); end
            n_cmp++; if (lat != 6) begin n_fail++; $display("FAIL passthrough_latency[%0d]: got %0d want 6", i, lat); end
        end
    endtask

    task automatic test_b1_b2();
        int us1[2] = '{500, 0};
        int ex1[2] = '{0, 500};
        int us2[3] = '{500, 0, 0};
        int ex2[3] = '{0, 0, 500};
        logic signed [21:0] y, e;
        int lat;
        set_band(0, 0, ONE, 0, 0, 0);
        do_flush();
        foreach (ex1[i]) exp_q.push_back(22'(ex1[i]));
        foreach (us1[i]) begin
            drive_sample(0, us1[i], 0, y, lat);
            e = exp_q.pop_front();
            n_cmp++; if (y !== e) begin n_fail++; $display("FAIL b1_delay[%0d]: yk %0d want %0d", i, y, e); end
        end
        set_band(0, 0, 0, ONE, 0, 0);
        do_flush();
        foreach (ex2[i]) exp_q.push_back(22'(ex2[i]));
        foreach (us2[i]) begin
            drive_sample(0, us2[i], 0, y, lat);
            e = exp_q.pop_front();
            n_cmp++; if (y !== e) begin n_fail++; $display("FAIL b2_delay[%0d]: yk %0d want %0d", i, y, e); end
        end
    endtask

    task automatic test_recursion();
        int us[3] = '{16384, 0, 0};
        int ex[3] = '{16384, 8192, 4096};
        logic signed [21:0] y, e;
        int lat;
        set_band(1, ONE, 0, 0, 8192, 0);
        do_flush();
        foreach (ex[i]) exp_q.push_back(22'(ex[i]));
        foreach (us[i]) begin
            drive_sample(1, us[i], 0, y, lat);
            e = exp_q.pop_front();
            n_cmp++; if (y !== e) begin n_fail++; $display("FAIL recursion[%0d]: yk %0d want %0d", i, y, e); end
        end
    endtask

    task automatic test_interleave();
        int bs[6] = '{1, 0, 1, 0, 1, 0};
        int us[6] = '{16384, 1000, 0, 200, 0, 0};
        int ex[6] = '{16384, 1000, 8192, 1200, 4096, 200};
        logic signed [21:0] y, e;
        int lat;
        set_band(0, ONE, ONE, 0, 0, 0);
        do_flush();
        foreach (ex[i]) exp_q.push_back(22'(ex[i]));
        foreach (us[i]) begin
            drive_sample(bs[i], us[i], 0, y, lat);
            e = exp_q.pop_front();
            n_cmp++; if (y !== e) begin n_fail++; $display("FAIL interleave[%0d]: yk %0d want %0d", i, y, e); end
        end
    endtask

    task automatic test_flush();
        int us[5] = '{16384, 0, 16384, 0, 0};
        int fa[5] = '{0, 100, 0, 3, 0};
        int ex[5] = '{16384, 0, 16384, 8192, 0};
        logic signed [21:0] y, e;
        int lat;
        do_flush();
        foreach (ex[i]) exp_q.push_back(22'(ex[i]));
        foreach (us[i]) begin
            drive_sample(1, us[i], fa[i], y, lat);
            e = exp_q.pop_front();
            n_cmp++; if (y !== e) begin n_fail++; $display("FAIL flush[%0d]: yk %0d want %0d", i, y, e); end
        end
    endtask

    task automatic test_bad_band();
        logic signed [21:0] y, e;
        int lat;
        do_flush();
        write_coef(3, 0, 5 * ONE);
        write_coef(0, 5, 3 * ONE);
        exp_q.push_back(22'sd0);
        exp_q.push_back(22'sd100);
        exp_q.push_back(22'sd100);
        drive_sample(3, 1000, 0, y, lat);
        e = exp_q.pop_front();
        n_cmp++; if (y !== e) begin n_fail++; $display("FAIL bad_band: yk %0d want %0d", y, e); end
        n_cmp++; if (lat != 6) begin n_fail++; $display("FAIL bad_band_latency: got %0d want 6", lat); end
        drive_sample(0, 100, 0, y, lat);
        e = exp_q.pop_front();
        n_cmp++; if (y !== e) begin n_fail++; $display("FAIL bad_band_isolation: yk %0d want %0d", y, e); end
        drive_sample(0, 0, 0, y, lat);
        e = exp_q.pop_front();
        n_cmp++; if (y !== e) begin n_fail++; $display("FAIL bad_band_state: yk %0d want %0d", y, e); end
    endtask

    task automatic test_overflow();
        logic signed [21:0] y, e;
        int lat;
        set_band(0, 4 * ONE, 0, 0, 0, 0);
        do_flush();
`ifdef FILTRO_SATURACION_EN
        exp_q.push_back(22'sd2097151);
        exp_q.push_back(-22'sd2097152);
`else
        exp_q.push_back(22'sd0);
        exp_q.push_back(22'sd0);
`endif
        drive_sample(0, 1048576, 0, y, lat);
        e = exp_q.pop_front();
        n_cmp++; if (y !== e) begin n_fail++; $display("FAIL overflow_pos: yk %0d want %0d", y, e); end
        drive_sample(0, -1048576, 0, y, lat);
        e = exp_q.pop_front();
        n_cmp++; if (y !== e) begin n_fail++; $display("FAIL overflow_neg: yk %0d want %0d", y, e); end
    endtask

    task automatic test_reset_midrun();
        logic signed [21:0] y, e;
        int lat;
        bit seen;
        set_band(0, ONE, 0, 0, 0, 0);
        in_valid = 1'b1;
        band_sel = 2'd0;
        uk       = 22'sd777;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL busy_in_ready: got %b want 0", in_ready); end
        repeat (2) tick();
        reset = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrun_reset_in_ready: got %b want 1", in_ready); end
        tick();
        reset = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midrun_no_out_valid: got %b want 0", seen); end
        n_cmp++; if (yk !== 22'sd0) begin n_fail++; $display("FAIL midrun_yk: got %0d want 0", yk); end
        exp_q.push_back(22'sd0);
        drive_sample(0, 777, 0, y, lat);
        e = exp_q.pop_front();
        n_cmp++; if (y !== e) begin n_fail++; $display("FAIL midrun_coefs_cleared: yk %0d want %0d", y, e); end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_b1_b2();
        test_recursion();
        test_interleave();
        test_flush();
        test_bad_band();
        test_overflow();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
